// File: rtl/data_sram_slave.sv
// Word-addressed SRAM slave with a fixed-latency, in-order response pipeline.
// Read data is captured at acceptance and held in a small pending buffer until its age reaches LATENCY.
module data_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic [31:0] rdata,
    output logic        data_ok
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int AW = $clog2(LATENCY + 1);

    localparam logic [AW-1:0] AGE_DONE = AW'(LATENCY);
    localparam logic [CW-1:0] CNT_MAX  = CW'(OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);

    logic [31:0]            mem [DEPTH];
    logic [31:0]            buf_data [OUTSTANDING];
    logic [AW-1:0]          buf_age  [OUTSTANDING];
    logic [OUTSTANDING-1:0] buf_wr;
    logic [OUTSTANDING-1:0] buf_valid;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          count;

    logic          accept;
    logic          head_done;
    logic [IW-1:0] idx;
    logic          unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign idx         = addr[IW+1:2];
    assign unused_bits = ^{size, addr[31:IW+2], addr[1:0]};

    // addr_ok looks only at registered count, so a retiring entry cannot reopen the slot in the same cycle
    assign addr_ok   = (count < CNT_MAX);
    assign accept    = req & addr_ok & resetn;
    assign head_done = buf_valid[head] && (buf_age[head] == AGE_DONE);

    assign data_ok = head_done;
    assign rdata   = (head_done && !buf_wr[head]) ? buf_data[head] : 32'h0;

    // Memory contents survive reset
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_data[tail] <= wr ? 32'h0 : mem[idx];
            buf_wr[tail]   <= wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            buf_valid <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                buf_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (buf_valid[i] && buf_age[i] != AGE_DONE) begin
                    buf_age[i] <= buf_age[i] + 1'b1;
                end
            end

            if (head_done) begin
                buf_valid[head] <= 1'b0;
                head            <= ptr_inc(head);
            end

            // A new entry is visible one cycle after acceptance, hence it starts at age 1
            if (accept) begin
                buf_valid[tail] <= 1'b1;
                buf_age[tail]   <= AW'(1);
                tail            <= ptr_inc(tail);
            end

            case ({accept, head_done})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed bench for data_sram_slave: default-parameter instance for data paths,
// and a shallow-queue instance (OUTSTANDING=2, LATENCY=4) for addr_ok throttling.
module tb_data_sram_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic [31:0] rdata;
    logic        data_ok;

    logic        req1;
    logic        addr_ok1;
    logic [31:0] rdata1;
    logic        data_ok1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_sram_slave dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .rdata   (rdata),
        .data_ok (data_ok)
    );

    data_sram_slave #(.DEPTH(1024), .LATENCY(4), .OUTSTANDING(2)) dut_q2 (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req1),
        .wr      (1'b0),
        .size    (2'b00),
        .wstrb   (4'h0),
        .addr    (32'h0),
        .wdata   (32'h0),
        .addr_ok (addr_ok1),
        .rdata   (rdata1),
        .data_ok (data_ok1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req   = r;
        wr    = w;
        wstrb = s;
        addr  = a;
        wdata = d;
    endtask

    // One cycle on the default instance: drive, then check response and addr_ok mid-cycle
    task automatic vec(input string tag, input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic exp_ok, input logic [31:0] exp_data);
        tick();
        drive(r, w, s, a, d);
        @(negedge clk);
        check({tag, " data_ok"}, 32'(data_ok), 32'(exp_ok));
        check({tag, " rdata"}, rdata, exp_data);
        check({tag, " addr_ok"}, 32'(addr_ok), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] exp_aok1;
        logic [11:0] exp_dok1;
        logic [31:0] exp_rd;

        resetn = 1'b0;
        size   = 2'b00;
        req1   = 1'b0;
        drive(0, 0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        tick();
        @(negedge clk);
        check("rst data_ok", 32'(data_ok), 32'h0);
        check("rst rdata", rdata, 32'h0);
        check("rst addr_ok", 32'(addr_ok), 32'h1);
        check("rst addr_ok q2", 32'(addr_ok1), 32'h1);
        check("rst data_ok q2", 32'(data_ok1), 32'h0);

        // write then read-after-write, LATENCY=2
        vec("raw c0", 1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        vec("raw c1", 1, 0, 4'h0, 32'h10, 32'h0,        0, 32'h0);
        vec("raw c2", 0, 0, 4'h0, 32'h0,  32'h0,        1, 32'h0);
        vec("raw c3", 0, 0, 4'h0, 32'h0,  32'h0,        1, 32'hDEADBEEF);
        vec("raw c4", 0, 0, 4'h0, 32'h0,  32'h0,        0, 32'h0);

        // byte strobes, then an all-zero strobe write that must not modify memory
        vec("strb c0", 1, 1, 4'hF,    32'h20, 32'h11223344, 0, 32'h0);
        vec("strb c1", 1, 1, 4'b0101, 32'h20, 32'hAABBCCDD, 0, 32'h0);
        vec("strb c2", 1, 0, 4'h0,    32'h20, 32'h0,        1, 32'h0);
        vec("strb c3", 1, 1, 4'h0,    32'h20, 32'hFFFFFFFF, 1, 32'h0);
        vec("strb c4", 1, 0, 4'h0,    32'h20, 32'h0,        1, 32'h11BB33DD);
        vec("strb c5", 0, 0, 4'h0,    32'h0,  32'h0,        1, 32'h0);
        vec("strb c6", 0, 0, 4'h0,    32'h0,  32'h0,        1, 32'h11BB33DD);
        vec("strb c7", 0, 0, 4'h0,    32'h0,  32'h0,        0, 32'h0);

        // 8 back-to-back writes then 8 back-to-back reads at 0x00..0x1C
        for (int k = 0; k < 18; k++) begin
            exp_rd = (k >= 10) ? (32'hC0DE0000 + 32'(k - 10)) : 32'h0;
            vec($sformatf("b2b c%0d", k), k < 16, k < 8, 4'hF, 32'(4 * (k % 8)),
                32'hC0DE0000 + 32'(k % 8), k >= 2, exp_rd);
        end

        // addresses wrap modulo DEPTH*4
        vec("wrap c0", 1, 1, 4'hF, 32'h1000, 32'h5A5A5A5A, 0, 32'h0);
        vec("wrap c1", 1, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0);
        vec("wrap c2", 0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h0);
        vec("wrap c3", 0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h5A5A5A5A);

        // reset mid-flight, with a write presented during reset that must be dropped
        vec("mrst c0", 1, 0, 4'h0, 32'h20, 32'h0, 0, 32'h0);
        vec("mrst c1", 1, 0, 4'h0, 32'h0,  32'h0, 0, 32'h0);
        tick();
        resetn = 1'b0;
        drive(1, 1, 4'hF, 32'h20, 32'hBAD0BAD0);
        tick();
        resetn = 1'b1;
        drive(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("mrst c3 data_ok", 32'(data_ok), 32'h0);
        check("mrst c3 addr_ok", 32'(addr_ok), 32'h1);
        for (int k = 4; k < 8; k++) begin
            vec($sformatf("mrst c%0d", k), 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0);
        end
        vec("mrst c8",  1, 0, 4'h0, 32'h20, 32'h0, 0, 32'h0);
        vec("mrst c9",  0, 0, 4'h0, 32'h0,  32'h0, 0, 32'h0);
        vec("mrst c10", 0, 0, 4'h0, 32'h0,  32'h0, 1, 32'h11BB33DD);
        vec("mrst c11", 0, 0, 4'h0, 32'h0,  32'h0, 0, 32'h0);

        // shallow queue: req held high, bit k is cycle k
        exp_aok1 = 12'b110001100011;
        exp_dok1 = 12'b011000110000;
        for (int k = 0; k < 12; k++) begin
            tick();
            req1 = 1'b1;
            @(negedge clk);
            check($sformatf("q2 c%0d addr_ok", k), 32'(addr_ok1), 32'(exp_aok1[k]));
            check($sformatf("q2 c%0d data_ok", k), 32'(data_ok1), 32'(exp_dok1[k]));
            if (!exp_dok1[k]) begin
                check($sformatf("q2 c%0d rdata", k), rdata1, 32'h0);
            end
        end
        tick();
        req1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
